// File: rtl/booth4_scheduler.sv
// -----------------------------------------------------------------------------
// booth4_scheduler
//
// Shares one booth4 radix-4 8x8 signed multiplier among N_REQ requesters with
// strict round-robin arbitration. Each job: grant in IDLE, load the
// multiplicand (with the enable pulse), load the multiplier, wait for done,
// read the product back high byte then low byte, and pulse a response to the
// owning requester. Jobs never overlap.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  WAIT-state watchdog limit in cycles (used only when the macro
//            BOOTH4_SCHED_TIMEOUT_EN is defined)
//
// Optional feature macro: BOOTH4_SCHED_TIMEOUT_EN
//   defined   : WAIT is bounded to TIMEOUT cycles; on expiry the job is
//               answered with rsp_product=0 and rsp_err=1.
//   undefined : WAIT lasts until mul_done; rsp_err is always 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid[N_REQ]         requester i has a job pending
//   req_a/req_b[8*N_REQ]     signed operands, slice [8i+7:8i]
//   req_ready[N_REQ]         one-hot grant, asserted only in IDLE
//   rsp_valid[N_REQ]         one-hot, single-cycle response strobe
//   rsp_product[16]          signed product {hi,lo}, valid with rsp_valid
//   rsp_err                  response produced by the watchdog
//   busy                     FSM not in IDLE
//   mul_enable, mul_inbus    start pulse and operand bus to booth4
//   mul_done, mul_outbus     done flag and result bus from booth4
//
// Handshake: a job from requester i is accepted on a rising edge where
// req_valid[i] & req_ready[i]. req_ready is a pure function of req_valid and
// the round-robin pointer while in IDLE, so acceptance is unconditional once
// granted. Responses have no backpressure: rsp_valid is a single-cycle pulse.
// -----------------------------------------------------------------------------
module booth4_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_product,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_enable,
  output logic [7:0]         mul_inbus,
  input  logic               mul_done,
  input  logic [7:0]         mul_outbus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // READ_HI has no state of its own: the high byte is captured on the same
  // cycle mul_done is seen in WAIT.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_M  = 3'd1,
    S_LOAD_Q  = 3'd2,
    S_WAIT    = 3'd3,
    S_READ_LO = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // Round-robin pick: lowest requesting index at or above rr_ptr, otherwise
  // the lowest requesting index overall (wrap-around).
  // ---------------------------------------------------------------------------
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             upper_found;
  logic [IDX_W-1:0] upper_idx;
  logic [IDX_W-1:0] lower_idx;

  always_comb begin
    win_found   = 1'b0;
    upper_found = 1'b0;
    upper_idx   = '0;
    lower_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !win_found) begin
        win_found = 1'b1;
        lower_idx = IDX_W'(i);
      end
      if (req_valid[i] && !upper_found && (IDX_W'(i) >= rr_ptr_q)) begin
        upper_found = 1'b1;
        upper_idx   = IDX_W'(i);
      end
    end
    win_idx = upper_found ? upper_idx : lower_idx;
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef BOOTH4_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // wait_cnt_q counts WAIT cycles already spent, so the hit fires on the
  // TIMEOUT-th WAIT cycle and RESP follows on the next edge.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: next state, datapath latches and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_product = '0;
    rsp_err     = 1'b0;
    mul_enable  = 1'b0;
    mul_inbus   = '0;

    unique case (state_q)
      S_IDLE: begin
        // rst gating keeps req_ready low while reset is held.
        if (win_found && !rst) begin
          req_ready[win_idx] = 1'b1;
          a_d      = req_a[{win_idx, 3'b000} +: 8];
          b_d      = req_b[{win_idx, 3'b000} +: 8];
          owner_d  = win_idx;
          err_d    = 1'b0;
          rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = S_LOAD_M;
        end
      end
      S_LOAD_M: begin
        mul_enable = 1'b1;
        mul_inbus  = a_q;
        state_d    = S_LOAD_Q;
      end
      S_LOAD_Q: begin
        mul_inbus = b_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          hi_d    = mul_outbus;
          state_d = S_READ_LO;
        end else if (timeout_hit) begin
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_READ_LO: begin
        lo_d    = mul_outbus;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_product        = {hi_q, lo_q};
        rsp_err            = err_q;
        state_d            = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
    end
  end

endmodule
